// File: rtl/conbus_arb.sv
// conbus_arb: shared-bus Wishbone interconnect, N_M masters to N_S slaves.
//
// Purpose
//   Round-robin arbitration among masters, top-address-bit decode to slaves,
//   and a one-cycle err response for unmapped addresses or a stalled slave
//   (watchdog). The ack/err/read-data path is purely combinational.
//
// Ports
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   m_dat_i/m_adr_i/m_sel_i  per-master write data, address, byte selects
//   m_we_i/m_cyc_i/m_stb_i   per-master control
//   m_dat_o                  read data broadcast to all masters
//   m_ack_o/m_err_o          per-master response, only the owner sees it
//   s_dat_o/s_adr_o/s_sel_o  owner write data / address / selects, broadcast
//   s_we_o                   owner write enable
//   s_cyc_o/s_stb_o          per-slave, only the decoded slave is driven
//   s_dat_i/s_ack_i          per-slave read data and acknowledge
//   grant_o                  one-hot current owner, zero when nobody owns

// One decode lane per slave: address match plus gated bus/response signals.
module conbus_arb_lane #(
    parameter int                  S_ADDR_W = 3,
    parameter logic [S_ADDR_W-1:0] BASE     = '0
) (
    input  logic [S_ADDR_W-1:0] top,
    input  logic                act,
    output logic                match,
    input  logic                hit,
    input  logic                stb_on,
    input  logic                s_ack,
    input  logic [31:0]         s_dat,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                ack,
    output logic [31:0]         dat
);
    assign match = act & (top == BASE);
    assign s_cyc = hit;
    assign s_stb = hit & stb_on;
    assign ack   = hit & s_ack;
    assign dat   = hit ? s_dat : 32'd0;
endmodule

module conbus_arb #(
    parameter int                          N_M      = 2,
    parameter int                          N_S      = 5,
    parameter int                          S_ADDR_W = 3,
    parameter logic [N_S*S_ADDR_W-1:0]     S_ADDR   = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter int                          TIMEOUT  = 255
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_M*32-1:0]    m_dat_i,
    input  logic [N_M*32-1:0]    m_adr_i,
    input  logic [N_M*4-1:0]     m_sel_i,
    input  logic [N_M-1:0]       m_we_i,
    input  logic [N_M-1:0]       m_cyc_i,
    input  logic [N_M-1:0]       m_stb_i,
    output logic [31:0]          m_dat_o,
    output logic [N_M-1:0]       m_ack_o,
    output logic [N_M-1:0]       m_err_o,
    output logic [31:0]          s_dat_o,
    output logic [31:0]          s_adr_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic [N_S-1:0]       s_cyc_o,
    output logic [N_S-1:0]       s_stb_o,
    input  logic [N_S*32-1:0]    s_dat_i,
    input  logic [N_S-1:0]       s_ack_i,
    output logic [N_M-1:0]       grant_o
);
    localparam int LW = $clog2(N_M);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // Request of the current owner, selected from the master buses.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } mreq_t;

    logic [N_M-1:0] owner;
    logic [LW-1:0]  last;
    logic [WW-1:0]  wcnt;

    logic [LW-1:0]  own_idx;
    mreq_t          req;
    logic           bus_free;

    logic           win_found;
    logic [LW-1:0]  win_idx;

    logic [N_S-1:0]        match;
    logic [N_S-1:0]        hit;
    logic                  hit_any;
    logic [N_S-1:0]        ack_v;
    logic [N_S-1:0][31:0]  dat_v;
    logic                  to_hit;
    logic                  err_now;
    logic                  ack_any;

    // ---------------------------------------------------------------
    // Owner request mux
    // ---------------------------------------------------------------
    always_comb begin
        own_idx = '0;
        for (int j = 0; j < N_M; j++)
            if (owner[j]) own_idx = LW'(j);
    end

    always_comb begin
        req.adr = m_adr_i[{own_idx, 5'd0} +: 32];
        req.dat = m_dat_i[{own_idx, 5'd0} +: 32];
        req.sel = m_sel_i[{own_idx, 2'd0} +: 4];
        req.we  = m_we_i[own_idx];
        req.cyc = |(owner & m_cyc_i);
        // stb from a master whose cyc is low is not a bus cycle.
        req.stb = |(owner & m_cyc_i & m_stb_i);
    end

    // Owner register holds until its cyc drops; covers owner == 0 too.
    assign bus_free = ~req.cyc;

    // ---------------------------------------------------------------
    // Round-robin: scan from last+1, the previous owner is checked last
    // ---------------------------------------------------------------
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_M; k++) begin
            c = int'(last) + k;
            if (c >= N_M) c = c - N_M;
            if (!win_found && m_cyc_i[c[LW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = c[LW-1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Address decode lanes
    // ---------------------------------------------------------------
    // Lowest-index match wins when base values overlap.
    always_comb begin
        logic taken;
        taken = 1'b0;
        hit   = '0;
        for (int i = 0; i < N_S; i++) begin
            if (match[i] && !taken) begin
                hit[i] = 1'b1;
                taken  = 1'b1;
            end
        end
    end

    assign hit_any = |match;
    assign to_hit  = (TIMEOUT > 0) && (wcnt == WW'(TIMEOUT));
    // Err covers unmapped strobes and the watchdog expiry; it also masks
    // the slave strobe and any ack arriving in the same cycle.
    assign err_now = req.stb & (~hit_any | to_hit);

    genvar gi;
    generate
        for (gi = 0; gi < N_S; gi++) begin : g_lane
            conbus_arb_lane #(
                .S_ADDR_W (S_ADDR_W),
                .BASE     (S_ADDR[gi*S_ADDR_W +: S_ADDR_W])
            ) u_lane (
                .top    (req.adr[31 -: S_ADDR_W]),
                .act    (req.cyc),
                .match  (match[gi]),
                .hit    (hit[gi]),
                .stb_on (req.stb & ~err_now),
                .s_ack  (s_ack_i[gi]),
                .s_dat  (s_dat_i[gi*32 +: 32]),
                .s_cyc  (s_cyc_o[gi]),
                .s_stb  (s_stb_o[gi]),
                .ack    (ack_v[gi]),
                .dat    (dat_v[gi])
            );
        end
    endgenerate

    assign ack_any = (|ack_v) & ~err_now;

    always_comb begin
        m_dat_o = 32'd0;
        for (int i = 0; i < N_S; i++)
            m_dat_o = m_dat_o | dat_v[i];
    end

    // ---------------------------------------------------------------
    // Master / slave side outputs
    // ---------------------------------------------------------------
    assign m_ack_o = owner & {N_M{ack_any}};
    assign m_err_o = owner & {N_M{err_now}};
    assign grant_o = owner;

    assign s_adr_o = req.cyc ? req.adr : 32'd0;
    assign s_dat_o = req.cyc ? req.dat : 32'd0;
    assign s_sel_o = req.cyc ? req.sel : 4'd0;
    assign s_we_o  = req.cyc & req.we;

    // ---------------------------------------------------------------
    // State: owner, last, watchdog
    // ---------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            owner <= '0;
            last  <= LW'(N_M - 1);
            wcnt  <= '0;
        end else if (bus_free) begin
            owner <= win_found ? (N_M'(1) << win_idx) : '0;
            if (win_found) last <= win_idx;
            wcnt  <= '0;
        end else if ((TIMEOUT > 0) && req.stb && !ack_any && !err_now) begin
            wcnt <= wcnt + WW'(1);
        end else begin
            wcnt <= '0;
        end
    end

endmodule

// File: doc/conbus_arb.md
# conbus_arb

Parametrised Wishbone shared-bus interconnect: the next-generation conbus for the LM32 SoC. It connects N_M masters to N_S slaves over one shared bus using round-robin arbitration and top-address-bit decode. Unlike conbus, it flags unmapped addresses and hung slaves with a one-cycle `err` response, so a missing peripheral cannot stall the CPU. It sits between `lm32_cpu` (instruction/data masters) and the bram/i2c/spi/gpio/timer slaves.

## Interface
- N_M, 2, number of masters (2..8)
- N_S, 5, number of slaves (1..8)
- S_ADDR_W, 3, number of top address bits decoded
- S_ADDR, {3'd4,3'd3,3'd2,3'd1,3'd0}, packed N_S×S_ADDR_W base values; slave i uses slice i
- TIMEOUT, 255, stalled-stb cycles before bus error; 0 disables the watchdog
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- m_dat_i  in  N_M*32  master write data, master j at [32j+31:32j]
- m_adr_i  in  N_M*32  master byte address
- m_sel_i  in  N_M*4  byte selects
- m_we_i, m_cyc_i, m_stb_i  in  N_M each  per-master control
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o  out  N_M  acknowledge, owner only
- m_err_o  out  N_M  error, owner only
- s_dat_o  out  32  owner write data, broadcast
- s_adr_o  out  32  owner address, broadcast
- s_sel_o  out  4  owner selects
- s_we_o  out  1  owner write enable
- s_cyc_o, s_stb_o  out  N_S each  per-slave, only the decoded slave is active
- s_dat_i  in  N_S*32  slave read data
- s_ack_i  in  N_S  slave acknowledge
- grant_o  out  N_M  one-hot current owner; all zero when the bus is free

## Operation
- Registers: `owner` (one-hot, N_M bits); `last` (index of previous owner); `wcnt` (watchdog counter, width clog2(TIMEOUT+1)).
- The bus is free when `owner` == 0 or the owner's cyc is low. While the bus is free, the arbiter evaluates `m_cyc_i` every cycle.
- Arbitration is round-robin. The scan starts at (last+1) mod N_M. The first master with cyc high wins.
- At the edge, `owner` ← the winner and `last` ← its index. If no master requests, `owner` ← 0.
- Ownership persists across multiple stb cycles for as long as the owner's cyc stays high (locked bursts).
- Decode: `hit[i]` = (owner adr[31 -: S_ADDR_W] == S_ADDR slice i). The lowest i wins if base values overlap.
- `s_cyc_o[i]` = owner cyc & hit[i]. `s_stb_o[i]` = owner stb & hit[i] & ~err_now.
- `m_ack_o[owner]` = OR over i of (s_ack_i[i] & hit[i]). `m_dat_o` = s_dat_i of the hit slave, else 0.
- Unmapped access: owner stb high with no hit gives `m_err_o[owner]` = 1 combinationally, for every such cycle. All s_cyc/s_stb stay 0.
- Watchdog, when TIMEOUT > 0:
  - `wcnt` increments each cycle the owner stb is high and ack is low.
  - `wcnt` clears on ack, on stb low, on an error, or on an owner change.
- Timeout error: err_now = (wcnt == TIMEOUT). This asserts `m_err_o[owner]` for exactly one cycle and gates `s_stb_o` low in that cycle.
- ack and err are never asserted together. Err takes precedence; the slave's ack is dropped in the err cycle.
- Reset: `owner`=0, `last`=N_M-1 (so master 0 is first after reset), `wcnt`=0.
- Outputs after reset: all s_cyc/s_stb/m_ack/m_err/grant_o = 0; `m_dat_o` = 0.

## Timing
- Grant latency is 1 cycle. A cyc that rises in cycle k of a free bus gives grant_o and slave strobes in cycle k+1.
- Handover has zero dead cycles. If the owner drops cyc in cycle k and another master requests, the new owner is active in cycle k+1.
- The ack/err/data path is combinational slave → master with no added latency. A zero-wait slave completes in the same cycle as its strobe.
- Timeout: stb first high in cycle 1 with no ack gives err in cycle TIMEOUT+1. The count restarts at the next edge if stb stays high.
- An owner dropping cyc mid-wait releases the bus at the next edge, clears `wcnt`, and raises no error.
- Reset mid-transaction: all strobes are 0 in the cycle after sys_rst is sampled high.
- A master that is not the owner never sees ack or err, and its stb is ignored.

## Test plan
- Single master, N_M=2, N_S=5. M0 reads 0x6000_0010 and slave 3 acks on its first strobe cycle with 0xDEADBEEF.
  - grant_o=01 one cycle after cyc rises.
  - s_stb_o=5'b01000.
  - m_dat_o=0xDEADBEEF with m_ack_o=01 in the same cycle.
- Round-robin: M0 and M1 hold cyc continuously and each drops cyc after 1 ack.
  - Grant sequence is M0, M1, M0, M1 with no idle cycles between owners.
- Unmapped: S_ADDR covers 0..4 and M1 strobes 0xE000_0000.
  - m_err_o=10 while stb is high.
  - All s_cyc_o=0 and m_ack_o=0.
- Timeout with TIMEOUT=4: a slave never acks.
  - m_err_o pulses in cycle 5 of the strobe, and s_stb_o is 0 in that cycle.
  - The pulse repeats in cycle 10 if stb is held.
- Locked burst: M0 holds cyc over 4 stb/ack beats while M1 requests throughout.
  - M1 is granted only in the cycle after M0's cyc falls.
- Reset mid-wait: assert sys_rst while wcnt=2 and M1 is the owner.
  - Next cycle: grant_o=0, strobes 0, wcnt=0.
  - The first grant after reset goes to M0 when both request.
